// File: rtl/control_sequencer_pkg.sv
// rtl/control_sequencer_pkg.sv - shared opcode type and datapath select encodings
package riscv_package;

  typedef enum logic [6:0] {
    Load                                   = 7'b0000011,
    Store                                  = 7'b0100011,
    Branch                                 = 7'b1100011,
    Jump_And_Link                          = 7'b1101111,
    Jump_And_Link_Register                 = 7'b1100111,
    Immediate_Arithmetic                   = 7'b0010011,
    Register_Arithmetic                    = 7'b0110011,
    Add_Upper_Immediate_To_Program_Counter = 7'b0010111,
    Load_Upper_Immediate                   = 7'b0110111,
    Fence                                  = 7'b0001111,
    System                                 = 7'b1110011
  } opcode_t;

  localparam logic [1:0] WRITE_SOURCE_ALU       = 2'd0;
  localparam logic [1:0] WRITE_SOURCE_MEMORY    = 2'd1;
  localparam logic [1:0] WRITE_SOURCE_PC_PLUS_4 = 2'd2;
  localparam logic [1:0] WRITE_SOURCE_IMMEDIATE = 2'd3;

  localparam logic [1:0] PC_SELECT_PLUS_4       = 2'd0;
  localparam logic [1:0] PC_SELECT_ALU          = 2'd1;
  localparam logic [1:0] PC_SELECT_ALU_CLEAR_0  = 2'd2;

endpackage

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - multi-cycle fetch/decode/execute/memory/writeback controller
module control_sequencer
  import riscv_package::*;
#(
  parameter int COUNTER_WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [6:0]               opcode,
  input  logic                     branch_taken,
  input  logic                     memory_ready,
  output logic                     memory_request,
  output logic                     memory_write,
  output logic                     memory_address_select,
  output logic                     instruction_register_enable,
  output logic                     alu_a_select,
  output logic                     alu_b_select,
  output logic                     register_write_enable,
  output logic [1:0]               register_write_source,
  output logic                     program_counter_enable,
  output logic [1:0]               program_counter_select,
  output logic                     halted,
  output logic [COUNTER_WIDTH-1:0] retired_count
);

  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT} state_t;

  state_t  state;
  opcode_t op;

  assign op = opcode_t'(opcode);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= FETCH;
      retired_count <= '0;
    end else begin
      if (program_counter_enable)
        retired_count <= retired_count + COUNTER_WIDTH'(1);
      case (state)
        FETCH:
          if (memory_ready) state <= DECODE;
        DECODE:
          case (op)
            Load, Store, Branch, Jump_And_Link, Jump_And_Link_Register,
            Immediate_Arithmetic, Register_Arithmetic,
            Add_Upper_Immediate_To_Program_Counter, Load_Upper_Immediate,
            Fence:   state <= EXECUTE;
            default: state <= HALT;
          endcase
        EXECUTE:
          case (op)
            Branch, Fence: state <= FETCH;
            Load, Store:   state <= MEMORY;
            default:       state <= WRITEBACK;
          endcase
        MEMORY:
          if (memory_ready) state <= (op == Store) ? FETCH : WRITEBACK;
        WRITEBACK:
          state <= FETCH;
        default:
          state <= HALT;
      endcase
    end
  end

  // Outputs decode the state register; reset forces them low at once, even mid-access.
  always_comb begin
    memory_request              = 1'b0;
    memory_write                = 1'b0;
    memory_address_select       = 1'b0;
    instruction_register_enable = 1'b0;
    alu_a_select                = 1'b0;
    alu_b_select                = 1'b0;
    register_write_enable       = 1'b0;
    register_write_source       = WRITE_SOURCE_ALU;
    program_counter_enable      = 1'b0;
    program_counter_select      = PC_SELECT_PLUS_4;
    halted                      = 1'b0;
    if (!reset) begin
      // ALU operand selects stay put from EXECUTE through WRITEBACK so the result is stable.
      if (state == EXECUTE || state == MEMORY || state == WRITEBACK) begin
        alu_a_select = op inside {Branch, Jump_And_Link, Add_Upper_Immediate_To_Program_Counter};
        alu_b_select = op inside {Immediate_Arithmetic, Load, Store, Branch, Jump_And_Link,
                                  Jump_And_Link_Register, Add_Upper_Immediate_To_Program_Counter};
      end
      case (state)
        FETCH: begin
          memory_request              = 1'b1;
          instruction_register_enable = memory_ready;
        end
        EXECUTE: begin
          if (op == Branch) begin
            program_counter_enable = 1'b1;
            program_counter_select = branch_taken ? PC_SELECT_ALU : PC_SELECT_PLUS_4;
          end else if (op == Fence) begin
            program_counter_enable = 1'b1;
          end
        end
        MEMORY: begin
          memory_request         = 1'b1;
          memory_address_select  = 1'b1;
          memory_write           = (op == Store);
          program_counter_enable = (op == Store) && memory_ready;
        end
        WRITEBACK: begin
          register_write_enable  = 1'b1;
          program_counter_enable = 1'b1;
          case (op)
            Load:                 register_write_source = WRITE_SOURCE_MEMORY;
            Load_Upper_Immediate: register_write_source = WRITE_SOURCE_IMMEDIATE;
            Jump_And_Link: begin
              register_write_source  = WRITE_SOURCE_PC_PLUS_4;
              program_counter_select = PC_SELECT_ALU;
            end
            Jump_And_Link_Register: begin
              register_write_source  = WRITE_SOURCE_PC_PLUS_4;
              program_counter_select = PC_SELECT_ALU_CLEAR_0;
            end
            default:              register_write_source = WRITE_SOURCE_ALU;
          endcase
        end
        HALT:
          halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - scoreboard bench for control_sequencer
module tb_control_sequencer;

  localparam logic [6:0] OP_ADDI  = 7'b0010011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_FENCE = 7'b0001111;
  localparam logic [6:0] OP_ECALL = 7'b1110011;
  localparam logic [6:0] OP_BAD   = 7'b1111111;

  logic        clock = 1'b0;
  logic        reset;
  logic [6:0]  opcode;
  logic        branch_taken;
  logic        memory_ready;
  logic        memory_request, memory_write, memory_address_select;
  logic        instruction_register_enable, alu_a_select, alu_b_select;
  logic        register_write_enable, program_counter_enable, halted;
  logic [1:0]  register_write_source, program_counter_select;
  logic [31:0] retired_count;

  logic        w_req, w_wr, w_as, w_ire, w_a, w_b, w_rwe, w_pce, w_halt;
  logic [1:0]  w_src, w_psel;
  logic [1:0]  w_count;

  always #5 clock = ~clock;

  control_sequencer u_dut (
    .clock(clock), .reset(reset), .opcode(opcode), .branch_taken(branch_taken),
    .memory_ready(memory_ready), .memory_request(memory_request), .memory_write(memory_write),
    .memory_address_select(memory_address_select),
    .instruction_register_enable(instruction_register_enable),
    .alu_a_select(alu_a_select), .alu_b_select(alu_b_select),
    .register_write_enable(register_write_enable), .register_write_source(register_write_source),
    .program_counter_enable(program_counter_enable),
    .program_counter_select(program_counter_select), .halted(halted),
    .retired_count(retired_count)
  );

  control_sequencer #(.COUNTER_WIDTH(2)) u_wrap (
    .clock(clock), .reset(reset), .opcode(OP_FENCE), .branch_taken(1'b0),
    .memory_ready(1'b1), .memory_request(w_req), .memory_write(w_wr),
    .memory_address_select(w_as), .instruction_register_enable(w_ire),
    .alu_a_select(w_a), .alu_b_select(w_b), .register_write_enable(w_rwe),
    .register_write_source(w_src), .program_counter_enable(w_pce),
    .program_counter_select(w_psel), .halted(w_halt), .retired_count(w_count)
  );

  logic [12:0] act_ctl;
  assign act_ctl = {memory_request, memory_write, memory_address_select,
                    instruction_register_enable, alu_a_select, alu_b_select,
                    register_write_enable, register_write_source, program_counter_enable,
                    program_counter_select, halted};

  typedef struct {
    logic [12:0] ctl;
    logic [31:0] cnt;
    int          id;
  } exp_t;

  exp_t        sbq[$];
  int          compared = 0;
  int          mismatched = 0;
  int          step_id = 0;
  logic [31:0] model_count = '0;

  function automatic logic [12:0] ctl(input logic req, wr, as, ire, a, b, rwe,
                                      input logic [1:0] src, input logic pce,
                                      input logic [1:0] psel, input logic halt);
    return {req, wr, as, ire, a, b, rwe, src, pce, psel, halt};
  endfunction

  // Drive one cycle of inputs and queue the outputs expected in that cycle.
  task automatic step(input logic [6:0] op, input logic bt, input logic mr, input logic [12:0] e);
    exp_t x;
    opcode       = op;
    branch_taken = bt;
    memory_ready = mr;
    x.ctl = e;
    x.cnt = model_count;
    x.id  = step_id;
    sbq.push_back(x);
    step_id++;
    if (e[3]) model_count++;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("reset_ctl", 64'(act_ctl), 64'd0);
    check("reset_count", 64'(retired_count), 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_count = '0;
  endtask

  always @(negedge clock) begin : monitor
    exp_t x;
    if (sbq.size() > 0) begin
      x = sbq.pop_front();
      compared++;
      if (act_ctl !== x.ctl || retired_count !== x.cnt) begin
        mismatched++;
        $display("FAIL step %0d: ctl=%b count=%0d expected ctl=%b count=%0d",
                 x.id, act_ctl, retired_count, x.ctl, x.cnt);
      end
    end
  end

  initial begin
    reset = 1'b1;
    opcode = '0;
    branch_taken = 1'b0;
    memory_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    do_reset();

    // ADDI, zero-wait fetch; stray ready in DECODE is ignored
    step(OP_ADDI, 0, 1, ctl(1,0,0,1,0,0,0,2'd0,0,2'd0,0));
    step(OP_ADDI, 0, 1, ctl(0,0,0,0,0,0,0,2'd0,0,2'd0,0));
    step(OP_ADDI, 0, 0, ctl(0,0,0,0,0,1,0,2'd0,0,2'd0,0));
    step(OP_ADDI, 0, 0, ctl(0,0,0,0,0,1,1,2'd0,1,2'd0,0));

    // LW, two fetch waits and three data waits: 10 cycles
    step(OP_LW, 0, 0, ctl(1,0,0,0,0,0,0,2'd0,0,2'd0,0));
    step(OP_LW, 0, 0, ctl(1,0,0,0,0,0,0,2'd0,0,2'd0,0));
    step(OP_LW, 0, 1, ctl(1,0,0,1,0,0,0,2'd0,0,2'd0,0));
    step(OP_LW, 0, 0, ctl(0,0,0,0,0,0,0,2'd0,0,2'd0,0));
    step(OP_LW, 0, 0, ctl(0,0,0,0,0,1,0,2'd0,0,2'd0,0));
    for (int i = 0; i < 3; i++)
      step(OP_LW, 0, 0, ctl(1,0,1,0,0,1,0,2'd0,0,2'd0,0));
    step(OP_LW, 0, 1, ctl(1,0,1,0,0,1,0,2'd0,0,2'd0,0));
    step(OP_LW, 0, 0, ctl(0,0,0,0,0,1,1,2'd1,1,2'd0,0));

    // branch taken, then not taken
    step(OP_BR, 0, 1, ctl(1,0,0,1,0,0,0,2'd0,0,2'd0,0));
    step(OP_BR, 0, 0, ctl(0,0,0,0,0,0,0,2'd0,0,2'd0,0));
    step(OP_BR, 1, 0, ctl(0,0,0,0,1,1,0,2'd0,1,2'd1,0));
    step(OP_BR, 0, 1, ctl(1,0,0,1,0,0,0,2'd0,0,2'd0,0));
    step(OP_BR, 0, 0, ctl(0,0,0,0,0,0,0,2'd0,0,2'd0,0));
    step(OP_BR, 0, 0, ctl(0,0,0,0,1,1,0,2'd0,1,2'd0,0));

    // JALR
    step(OP_JALR, 0, 1, ctl(1,0,0,1,0,0,0,2'd0,0,2'd0,0));
    step(OP_JALR, 0, 0, ctl(0,0,0,0,0,0,0,2'd0,0,2'd0,0));
    step(OP_JALR, 0, 0, ctl(0,0,0,0,0,1,0,2'd0,0,2'd0,0));
    step(OP_JALR, 0, 0, ctl(0,0,0,0,0,1,1,2'd2,1,2'd2,0));

    // SW with one data wait
    step(OP_SW, 0, 1, ctl(1,0,0,1,0,0,0,2'd0,0,2'd0,0));
    step(OP_SW, 0, 0, ctl(0,0,0,0,0,0,0,2'd0,0,2'd0,0));
    step(OP_SW, 0, 0, ctl(0,0,0,0,0,1,0,2'd0,0,2'd0,0));
    step(OP_SW, 0, 0, ctl(1,1,1,0,0,1,0,2'd0,0,2'd0,0));
    step(OP_SW, 0, 1, ctl(1,1,1,0,0,1,0,2'd0,1,2'd0,0));

    // LUI then FENCE
    step(OP_LUI, 0, 1, ctl(1,0,0,1,0,0,0,2'd0,0,2'd0,0));
    step(OP_LUI, 0, 0, ctl(0,0,0,0,0,0,0,2'd0,0,2'd0,0));
    step(OP_LUI, 0, 0, ctl(0,0,0,0,0,0,0,2'd0,0,2'd0,0));
    step(OP_LUI, 0, 0, ctl(0,0,0,0,0,0,1,2'd3,1,2'd0,0));
    step(OP_FENCE, 0, 1, ctl(1,0,0,1,0,0,0,2'd0,0,2'd0,0));
    step(OP_FENCE, 0, 0, ctl(0,0,0,0,0,0,0,2'd0,0,2'd0,0));
    step(OP_FENCE, 0, 0, ctl(0,0,0,0,0,0,0,2'd0,1,2'd0,0));

    // illegal opcode halts with count frozen at 8
    step(OP_BAD, 0, 1, ctl(1,0,0,1,0,0,0,2'd0,0,2'd0,0));
    step(OP_BAD, 0, 0, ctl(0,0,0,0,0,0,0,2'd0,0,2'd0,0));
    for (int i = 0; i < 3; i++)
      step(OP_BAD, 0, 1, ctl(0,0,0,0,0,0,0,2'd0,0,2'd0,1));
    check("count_after_halt", 64'(retired_count), 64'd8);

    do_reset();
    step(OP_ECALL, 0, 1, ctl(1,0,0,1,0,0,0,2'd0,0,2'd0,0));
    step(OP_ECALL, 0, 0, ctl(0,0,0,0,0,0,0,2'd0,0,2'd0,0));
    step(OP_ECALL, 0, 1, ctl(0,0,0,0,0,0,0,2'd0,0,2'd0,1));
    step(OP_ECALL, 0, 1, ctl(0,0,0,0,0,0,0,2'd0,0,2'd0,1));

    // reset asserted mid-MEMORY drops the request immediately
    do_reset();
    step(OP_LW, 0, 1, ctl(1,0,0,1,0,0,0,2'd0,0,2'd0,0));
    step(OP_LW, 0, 0, ctl(0,0,0,0,0,0,0,2'd0,0,2'd0,0));
    step(OP_LW, 0, 0, ctl(0,0,0,0,0,1,0,2'd0,0,2'd0,0));
    memory_ready = 1'b0;
    check("mem_request_in_memory", 64'(memory_request), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("mem_request_async_drop", 64'(memory_request), 64'd0);
    check("ctl_async_reset", 64'(act_ctl), 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_count = '0;
    step(OP_LW, 0, 0, ctl(1,0,0,0,0,0,0,2'd0,0,2'd0,0));

    // two-bit counter: 4 fence retires wrap to 0, the 5th gives 1
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (12) @(posedge clock);
    #1;
    check("wrap_after_4", 64'(w_count), 64'd0);
    repeat (3) @(posedge clock);
    #1;
    check("wrap_after_5", 64'(w_count), 64'd1);

    @(negedge clock);
    #1;
    check("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
